// File: rtl/bus85_resp.sv
// 8085 bus responder: internal RAM window plus one I/O port, with wait-state insertion
// and a sticky protocol-error flag.
module bus85_resp #(
    parameter int unsigned          DATASIZE = 8,
    parameter int unsigned          ADDRSIZE = 16,
    parameter int unsigned          MEMSIZE  = 12,
    parameter logic [ADDRSIZE-1:0]  MEMBASE  = 16'h0000,
    parameter logic [DATASIZE-1:0]  IOPORT   = 8'h80,
    parameter int unsigned          WAITS    = 1,
    parameter logic [DATASIZE-1:0]  INTVEC   = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    inout  wire  [DATASIZE-1:0]          addrdata,
    input  logic [ADDRSIZE-DATASIZE-1:0] addr,
    input  logic                         ale,
    input  logic                         rd_,
    input  logic                         wr_,
    input  logic                         iom_,
    input  logic                         inta_,
    output logic                         ready,
    input  logic [DATASIZE-1:0]          pin,
    output logic [DATASIZE-1:0]          pout,
    output logic                         buserr
);

    localparam int unsigned         MemWords  = 2 ** MEMSIZE;
    localparam logic [ADDRSIZE:0]   MemWordsW = {{ADDRSIZE{1'b0}}, 1'b1} << MEMSIZE;
    localparam logic [1:0]          WaitsW    = 2'(WAITS);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StAcc} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDRSIZE-1:0]   addr_q, addr_d;
    logic [DATASIZE-1:0]   pout_q, pout_d;
    logic                  buserr_q, buserr_d;
    logic [DATASIZE-1:0]   wdata_q, wdata_d;
    logic                  wpend_q, wpend_d;
    logic                  mem_sel_q, mem_sel_d;
    logic                  io_sel_q, io_sel_d;
    logic                  err_q, err_d;

    logic [DATASIZE-1:0]   mem_q [MemWords];

    logic [ADDRSIZE:0]     offset;
    logic                  in_win;
    logic                  io_hit;
    logic [MEMSIZE-1:0]    mem_idx;
    logic [1:0]            n_low;
    logic                  sel;
    logic                  mem_we;
    logic                  drive_en;
    logic [DATASIZE-1:0]   drive_val;

    // Borrow out of the subtraction marks addresses below the window.
    assign offset  = {1'b0, addr_q} - {1'b0, MEMBASE};
    assign in_win  = !offset[ADDRSIZE] && (offset < MemWordsW);
    assign mem_idx = offset[MEMSIZE-1:0];
    assign io_hit  = (addr_q[DATASIZE-1:0] == IOPORT);
    assign n_low   = {1'b0, ~rd_} + {1'b0, ~wr_} + {1'b0, ~inta_};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        pout_d    = pout_q;
        buserr_d  = buserr_q;
        wdata_d   = wdata_q;
        wpend_d   = 1'b0;
        mem_sel_d = mem_sel_q;
        io_sel_d  = io_sel_q;
        err_d     = err_q;
        sel       = 1'b0;
        mem_we    = 1'b0;

        if (ale) begin
            addr_d = {addr, addrdata};
        end

        unique case (state_q)
            StIdle: begin
                if (ale) state_d = StAddr;
            end
            StAddr: begin
                if (ale) begin
                    state_d = StAddr;
                end else if (n_low >= 2'd2) begin
                    buserr_d  = 1'b1;
                    err_d     = 1'b1;
                    mem_sel_d = 1'b0;
                    io_sel_d  = 1'b0;
                    state_d   = StAcc;
                end else if (n_low == 2'd1) begin
                    err_d     = 1'b0;
                    mem_sel_d = !iom_ && in_win;
                    io_sel_d  = iom_ && io_hit;
                    sel       = mem_sel_d || io_sel_d || !inta_;
                    if (sel && (WaitsW != 2'd0)) begin
                        state_d = StWait;
                        cnt_d   = WaitsW;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StWait: begin
                if (ale) begin
                    buserr_d = 1'b1;
                    cnt_d    = 2'd0;
                    state_d  = StAddr;
                end else if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = StAcc;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StAcc: begin
                wpend_d = wpend_q;
                // Keep resampling while wr_ is low; the last sample commits on its rise.
                if (!wr_ && !err_q && (mem_sel_q || io_sel_q)) begin
                    wpend_d = 1'b1;
                    wdata_d = addrdata;
                end else if (wpend_q && wr_) begin
                    wpend_d = 1'b0;
                    if (mem_sel_q) mem_we = 1'b1;
                    else           pout_d = wdata_q;
                end
                if (ale) begin
                    state_d = StAddr;
                end else if (rd_ && wr_ && inta_) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            addr_q    <= '0;
            pout_q    <= '0;
            buserr_q  <= 1'b0;
            wdata_q   <= '0;
            wpend_q   <= 1'b0;
            mem_sel_q <= 1'b0;
            io_sel_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            pout_q    <= pout_d;
            buserr_q  <= buserr_d;
            wdata_q   <= wdata_d;
            wpend_q   <= wpend_d;
            mem_sel_q <= mem_sel_d;
            io_sel_q  <= io_sel_d;
            err_q     <= err_d;
        end
    end

    // RAM has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= wdata_q;
    end

    always_comb begin
        drive_en  = (state_q == StAcc) && !err_q &&
                    (!inta_ || (!rd_ && (mem_sel_q || io_sel_q)));
        drive_val = pin;
        if (!inta_)         drive_val = INTVEC;
        else if (mem_sel_q) drive_val = mem_q[mem_idx];
    end

    assign addrdata = drive_en ? drive_val : {DATASIZE{1'bz}};
    assign ready    = (state_q != StWait);
    assign pout     = pout_q;
    assign buserr   = buserr_q;

endmodule

// File: tb/tb_bus85_resp.sv
// Randomized scoreboard bench for bus85_resp: stimulus queues expected bus results,
// an independent monitor observes each completed strobe and compares.
module tb_bus85_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr_hi, tb_ad, pin;
    logic       tb_oe, ale, rd_, wr_, iom_, inta_;
    wire  [7:0] addrdata;
    wire        ready;
    wire  [7:0] pout;
    wire        buserr;

    always #5 clk = ~clk;

    assign addrdata = tb_oe ? tb_ad : 8'bz;

    bus85_resp #(
        .DATASIZE(8), .ADDRSIZE(16), .MEMSIZE(12), .MEMBASE(16'h0000),
        .IOPORT(8'h80), .WAITS(1), .INTVEC(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .addrdata(addrdata), .addr(addr_hi), .ale(ale),
        .rd_(rd_), .wr_(wr_), .iom_(iom_), .inta_(inta_), .ready(ready),
        .pin(pin), .pout(pout), .buserr(buserr)
    );

    typedef struct {
        int         waits;
        bit         drv;
        logic [7:0] val;
        logic [7:0] pout;
        bit         berr;
    } exp_t;

    exp_t       expq[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic [7:0] mem_m [int];
    logic [7:0] pout_m = 8'h00;
    bit         berr_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one record per strobe-low period, finalized the clock after strobes rise.
    initial begin
        int         w;
        bit         active, seen, conflict, wz, multi;
        logic [7:0] sv;
        exp_t       e;
        active = 0; w = 0; seen = 0; conflict = 0; wz = 0; multi = 0; sv = 0;
        forever begin
            @(posedge clk); #1;
            if (!mon_en || rst) begin
                active = 0;
                continue;
            end
            if (!(rd_ && wr_ && inta_)) begin
                if (!active) begin
                    active = 1; w = 0; seen = 0; conflict = 0; wz = 0; multi = 0;
                end
                if (!ready) w++;
                if (tb_oe) begin
                    if (addrdata !== tb_ad) conflict = 1;
                end else if (addrdata !== 8'bz) begin
                    if (!ready) wz = 1;
                    else begin
                        if (seen && addrdata !== sv) multi = 1;
                        seen = 1;
                        sv   = addrdata;
                    end
                end
            end else if (active) begin
                active = 0;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got transaction, expected none");
                end else begin
                    e = expq.pop_front();
                    chk("waits", w, e.waits);
                    chk("drive_seen", seen, e.drv);
                    if (e.drv) chk("drive_val", sv, e.val);
                    chk("drive_stable", multi, 0);
                    chk("no_drive_in_wait", wz, 0);
                    chk("bus_conflict", conflict, 0);
                    chk("pout", pout, e.pout);
                    chk("buserr", buserr, e.berr);
                    chk("z_after", addrdata === 8'bz, 1);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 8);
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: ready=%0b required 1 within 8 clocks", name, ready);
        end
    endtask

    // kind: 0 read, 1 write, 2 interrupt ack, 3 read+write together (protocol error)
    task automatic access(input int kind, input logic [15:0] a, input logic iom,
                          input logic [7:0] wd);
        exp_t e;
        bit   msel, isel;
        msel = !iom && (a < 16'h1000);
        isel = iom && (a[7:0] == 8'h80);
        e.waits = 0; e.drv = 0; e.val = 8'h00;
        case (kind)
            0: if (msel || isel) begin
                   e.waits = 1; e.drv = 1; e.val = msel ? mem_m[int'(a)] : pin;
               end
            1: if (msel || isel) begin
                   e.waits = 1;
                   if (msel) mem_m[int'(a)] = wd;
                   else      pout_m = wd;
               end
            2: begin e.waits = 1; e.drv = 1; e.val = 8'hFF; end
            default: berr_m = 1;
        endcase
        e.pout = pout_m;
        e.berr = berr_m;
        expq.push_back(e);

        @(negedge clk);
        ale = 1; addr_hi = a[15:8]; tb_ad = a[7:0]; tb_oe = 1; iom_ = iom;
        @(negedge clk);
        ale = 0; tb_oe = (kind == 1); tb_ad = wd;
        rd_ = !(kind == 0 || kind == 3);
        wr_ = !(kind == 1 || kind == 3);
        inta_ = !(kind == 2);
        wait_ready("access");
        tb_ad = ~wd;
        @(negedge clk);
        tb_ad = wd;
        @(negedge clk);
        rd_ = 1; wr_ = 1; inta_ = 1; tb_oe = 0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] pool [8];
        logic [15:0] a;
        int          r;
        pool = '{16'h0010, 16'h0123, 16'h0FFF, 16'h0000, 16'h0555, 16'h0AAA, 16'h0800, 16'h07FF};
        ale = 0; rd_ = 1; wr_ = 1; inta_ = 1; iom_ = 0; tb_oe = 0; tb_ad = 0;
        addr_hi = 0; pin = 0;

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_z", addrdata === 8'bz, 1);
        chk("rst_pout", pout, 0);
        chk("rst_buserr", buserr, 0);
        rst = 0;
        mon_en = 1;

        access(1, 16'h0010, 0, 8'h3E);
        access(0, 16'h0010, 0, 8'h00);
        access(1, 16'h0123, 0, 8'hA5);
        access(0, 16'h0123, 0, 8'h00);
        access(1, 16'h2000, 0, 8'h11);
        access(0, 16'h2000, 0, 8'h00);
        access(1, 16'h1000, 0, 8'h22);
        access(1, 16'h8080, 1, 8'h5A);
        pin = 8'hC3;
        access(0, 16'h8080, 1, 8'h00);
        access(1, 16'h8181, 1, 8'h99);
        access(0, 16'h8181, 1, 8'h00);
        access(2, 16'h3838, 1, 8'h00);
        access(0, 16'h0123, 0, 8'h00);

        for (int i = 0; i < 200; i++) begin
            r   = $urandom_range(0, 8);
            a   = pool[$urandom_range(0, 7)];
            pin = 8'($urandom);
            case (r)
                0, 1, 2: access(1, a, 0, 8'($urandom));
                3, 4:    if (mem_m.exists(int'(a))) access(0, a, 0, 8'h00);
                         else access(1, a, 0, 8'($urandom));
                5: begin
                    a = 16'h1000 + 16'($urandom_range(0, 16'hEFFF));
                    access($urandom_range(0, 1), a, 0, 8'($urandom));
                end
                6: begin
                    a = {8'($urandom), 8'h80 + 8'($urandom_range(0, 1))};
                    access(1, a, 1, 8'($urandom));
                end
                7: access(0, {8'h80, 8'h80 + 8'($urandom_range(0, 1))}, 1, 8'h00);
                default: access(2, 16'($urandom), 1, 8'h00);
            endcase
        end

        // Both strobes low: sticky error, nothing written, next access still works.
        access(3, 16'h0123, 0, 8'h00);
        access(0, 16'h0123, 0, 8'h00);
        access(1, 16'h8080, 1, 8'h6C);

        // ALE during a wait state aborts the access.
        mon_en = 0;
        @(negedge clk);
        ale = 1; addr_hi = 8'h00; tb_ad = 8'h10; tb_oe = 1; iom_ = 0;
        @(negedge clk);
        ale = 0; tb_oe = 0; rd_ = 0;
        @(negedge clk);
        chk("wait_entered", ready, 0);
        chk("wait_z", addrdata === 8'bz, 1);
        ale = 1; tb_oe = 1;
        @(negedge clk);
        chk("ale_wait_buserr", buserr, 1);
        chk("ale_wait_ready", ready, 1);
        ale = 0; rd_ = 1; tb_oe = 0;
        @(negedge clk);
        mon_en = 1;
        access(0, 16'h0010, 0, 8'h00);

        // Reset clears the sticky error and pout.
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst2_buserr", buserr, 0);
        chk("rst2_pout", pout, 0);
        @(negedge clk);
        rst = 0;
        berr_m = 0;
        pout_m = 8'h00;

        // Reset in the middle of a memory write discards the write.
        mon_en = 0;
        @(negedge clk);
        ale = 1; addr_hi = 8'h01; tb_ad = 8'h23; tb_oe = 1; iom_ = 0;
        @(negedge clk);
        ale = 0; tb_ad = 8'h77; wr_ = 0;
        wait_ready("midwrite");
        @(negedge clk);
        rst = 1; tb_oe = 0;
        #1;
        chk("midwr_ready", ready, 1);
        chk("midwr_z", addrdata === 8'bz, 1);
        chk("midwr_pout", pout, 0);
        @(negedge clk);
        wr_ = 1;
        rst = 0;
        @(negedge clk);
        mon_en = 1;
        access(0, 16'h0123, 0, 8'h00);
        access(1, 16'h8080, 1, 8'h3C);

        repeat (3) @(negedge clk);
        chk("sb_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus85_resp.md
BUS85_RESP -- requirements
Module: bus85_resp

Interface
REQ-001 Parameter DATASIZE, default 8: width of the multiplexed address/data bus.
REQ-002 Parameter ADDRSIZE, default 16: full address width.
REQ-003 Parameter MEMSIZE, default 12: internal RAM holds 2**MEMSIZE bytes.
REQ-004 Parameter MEMBASE, default 16'h0000: RAM base address; must be aligned to 2**MEMSIZE.
REQ-005 Parameter IOPORT, default 8'h80: I/O port address.
REQ-006 Parameter WAITS, default 1, range 0..3: wait states inserted per selected access.
REQ-007 Parameter INTVEC, default 8'hFF: opcode supplied on interrupt acknowledge (RST 7).
REQ-008 clk  input  1  system clock; one clock only, all state changes on posedge clk.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 addrdata  inout  DATASIZE  multiplexed low address / data bus.
REQ-011 addr  input  ADDRSIZE-DATASIZE  high address byte.
REQ-012 ale, rd_, wr_, iom_, inta_  input  1 each  8085 bus strobes; rd_, wr_ and inta_ active-low; iom_ low selects memory.
REQ-013 ready  output  1  wait request to the core; low inserts wait states.
REQ-014 pin  input  DATASIZE  value returned by IN from IOPORT.
REQ-015 pout  output  DATASIZE  register written by OUT to IOPORT.
REQ-016 buserr  output  1  sticky protocol-error flag.

Function
REQ-017 At each posedge clk with ale=1, the block SHALL capture {addr, addrdata} into the latched address.
REQ-018 Memory select SHALL be iom_=0 and latched address in [MEMBASE, MEMBASE+2**MEMSIZE-1]; I/O select SHALL be iom_=1 and latched address low byte = IOPORT.
REQ-019 The FSM states SHALL be IDLE, ADDR, WAIT and ACC.
REQ-020 IDLE: ale=1 -> ADDR.
REQ-021 ADDR: ale=1 -> ADDR with the address recaptured.
REQ-022 ADDR: exactly one of rd_/wr_/inta_ low -> WAIT when selected (or inta_) and WAITS>0, otherwise ACC.
REQ-023 WAIT: the wait counter SHALL load WAITS on entry, decrement each clock, and leave for ACC in the clock it reaches 1.
REQ-024 ACC: rd_, wr_ and inta_ all sampled high -> IDLE; ale=1 -> ADDR.
REQ-025 ready SHALL be 0 exactly while the state is WAIT and 1 otherwise, giving WAITS clocks low per selected access.
REQ-026 addrdata SHALL be driven only in ACC with rd_=0, or in ACC with inta_=0, and SHALL be high-Z otherwise.
REQ-027 The driven value SHALL be RAM[latched address - MEMBASE] for a memory read, pin for an I/O read, and INTVEC for an acknowledge.
REQ-028 While wr_=0 in ACC, data SHALL be sampled every clock.
REQ-029 On the clock wr_ is sampled rising, the last sampled data SHALL commit to RAM (memory select) or pout (I/O select).
REQ-030 An unselected access SHALL insert no wait states, drive nothing and write nothing, and SHALL complete through ACC normally.
REQ-031 Two or more of rd_/wr_/inta_ sampled low together SHALL set buserr, suppress drive and write, and go to ACC.
REQ-032 ale=1 while in WAIT SHALL set buserr, abort the access and go to ADDR.
REQ-033 The RAM index SHALL use the low MEMSIZE bits of (address - MEMBASE); there is no wrap beyond the window.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, ready=1, addrdata high-Z, pout=0, buserr=0, wait counter 0, latched address 0.
REQ-035 Reset SHALL discard any pending write.
REQ-036 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-037 WAITS=1: ALE with address 16'h0010, then rd_ low with RAM[0x10]=8'h3E -> ready low for exactly 1 clock, then addrdata=8'h3E until rd_ rises, then high-Z.
REQ-038 Memory write 8'hA5 to 16'h0123, then a read of 16'h0123 -> 8'hA5 driven; write to 16'h2000 (outside the RAM window) -> no wait state, no drive, RAM unchanged.
REQ-039 I/O write 8'h5A to port 8'h80 -> pout=8'h5A after wr_ rises; I/O read with pin=8'hC3 -> 8'hC3 driven; port 8'h81 -> pout unchanged, high-Z.
REQ-040 inta_ low after ALE -> INTVEC (8'hFF) driven, with WAITS wait clocks first.
REQ-041 rd_ and wr_ low together -> buserr=1 and stays 1; next legal access works normally; rst -> buserr=0.
REQ-042 rst asserted mid-write (wr_ low, state ACC) -> ready=1, high-Z immediately; RAM at the target address unchanged; pout unchanged by the write.
